// File: rtl/iterative_divider_64_32_if.sv
// Operand/result bundle for the 2N-by-N restoring divider.
// Handshake: the master raises enable with A/B valid; the slave captures on that edge and later raises done
// while Q/R/err are valid, holding them until the master drops enable (which also frees the slave for a new start).
interface iterative_divider_64_32_if #(
    parameter int N = 32
);
    logic             enable;
    logic [2*N-1:0]   A;
    logic [N-1:0]     B;
    logic [N-1:0]     Q;
    logic [N-1:0]     R;
    logic             done;
    logic             err;

    modport master (
        output enable, A, B,
        input  Q, R, done, err
    );

    modport slave (
        input  enable, A, B,
        output Q, R, done, err
    );
endinterface

// File: rtl/iterative_divider_64_32.sv
// Unsigned 2N/N restoring divider: one quotient bit per clock, N run cycles after the capture edge.
// Illegal divisions (B==0 or quotient overflow) finish on the capture edge with err set.
module iterative_divider_64_32 #(
    parameter int N = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    iterative_divider_64_32_if.slave bus,
    output logic [1:0]               state_dbg
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [N:0]    rem, rem_nx;
    logic [N-1:0]  dvd, dvd_nx;
    logic [N-1:0]  div, div_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0]  q_r, q_nx;
    logic [N-1:0]  r_r, r_nx;
    logic          done_r, done_nx;
    logic          err_r, err_nx;

    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          fits;

    // rem stays below the divisor, so its top bit is zero in legal runs; it is still folded into fits.
    always_comb begin
        shifted = {rem[N-1:0], dvd[N-1]};
        diff    = shifted - {1'b0, div};
        fits    = rem[N] | (shifted >= {1'b0, div});
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        dvd_nx   = dvd;
        div_nx   = div;
        cnt_nx   = cnt;
        q_nx     = q_r;
        r_nx     = r_r;
        done_nx  = done_r;
        err_nx   = err_r;

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    div_nx = bus.B;
                    if (bus.B == '0 || bus.A[2*N-1:N] >= bus.B) begin
                        state_nx = DONE;
                        rem_nx   = '0;
                        dvd_nx   = '0;
                        q_nx     = '1;
                        r_nx     = '0;
                        err_nx   = 1'b1;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = RUN;
                        rem_nx   = {1'b0, bus.A[2*N-1:N]};
                        dvd_nx   = bus.A[N-1:0];
                        cnt_nx   = '0;
                    end
                end
            end

            RUN: begin
                // dvd doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
                rem_nx = fits ? diff : shifted;
                dvd_nx = {dvd[N-2:0], fits};
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    state_nx = DONE;
                    q_nx     = dvd_nx;
                    r_nx     = rem_nx[N-1:0];
                    err_nx   = 1'b0;
                    done_nx  = 1'b1;
                end
            end

            DONE: begin
                if (!bus.enable) begin
                    state_nx = IDLE;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            dvd    <= '0;
            div    <= '0;
            cnt    <= '0;
            q_r    <= '0;
            r_r    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            rem    <= rem_nx;
            dvd    <= dvd_nx;
            div    <= div_nx;
            cnt    <= cnt_nx;
            q_r    <= q_nx;
            r_r    <= r_nx;
            done_r <= done_nx;
            err_r  <= err_nx;
        end
    end

    assign bus.Q     = q_r;
    assign bus.R     = r_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign state_dbg = state;
endmodule

// File: tb/tb_iterative_divider_64_32.sv
// Directed bench for iterative_divider_64_32: vector table plus abort, operand-scramble and sweep sequences.
module tb_iterative_divider_64_32;
    localparam int N = 32;

    typedef struct {
        logic [2*N-1:0] a;
        logic [N-1:0]   b;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           err;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    iterative_divider_64_32_if #(.N(N)) bus ();

    iterative_divider_64_32 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    string            ctx   = "";
    logic [2*N:0]     exp_q[$];
    vec_t             vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h", ctx, name, got, want);
        end
    endtask

    // driver: start one division, follow it to done, then release enable
    task automatic run_op(input logic [2*N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] qv, input logic [N-1:0] rv,
                          input logic ev, input bit scramble);
        logic [2*N:0] exp;
        logic [N-1:0] q_prev;
        logic [N-1:0] r_prev;
        int           lat;
        bit           seen;
        bit           stable;

        exp_q.push_back({qv, rv, ev});
        q_prev     = bus.Q;
        r_prev     = bus.R;
        lat        = 0;
        seen       = 1'b0;
        stable     = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.enable = 1'b1;

        for (int e = 1; e <= 40 && !seen; e++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                lat  = e;
            end else if (bus.Q !== q_prev || bus.R !== r_prev || bus.err !== 1'b0) begin
                stable = 1'b0;
            end
            if (scramble && !seen) begin
                bus.A = {$urandom, $urandom};
                bus.B = $urandom;
                if (e == 5) bus.enable = 1'b0;
            end
        end

        check("latency", 64'(lat), ev ? 64'd1 : 64'(N + 1));
        check("outputs_quiet_in_run", 64'(stable), 64'd1);

        // scoreboard
        exp = exp_q.pop_front();
        check("Q", 64'(bus.Q), 64'(exp[2*N:N+1]));
        check("R", 64'(bus.R), 64'(exp[N:1]));
        check("err", 64'(bus.err), 64'(exp[0]));

        if (!scramble) begin
            tick();
            tick();
            check("done_hold", 64'({bus.done, bus.err}), 64'({1'b1, ev}));
            check("Q_hold", 64'(bus.Q), 64'(qv));
        end

        bus.enable = 1'b0;
        tick();
        check("done_drop", 64'({bus.done, bus.err}), 64'd0);
        check("Q_kept", 64'({bus.Q, bus.R}), 64'({qv, rv}));
        check("idle_state", 64'(state_dbg), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.A      = '0;
        bus.B      = '0;

        ctx = "reset";
        #3;
        check("Q", 64'(bus.Q), 64'd0);
        check("R", 64'(bus.R), 64'd0);
        check("done_err", 64'({bus.done, bus.err}), 64'd0);
        check("state", 64'(state_dbg), 64'd0);
        tick();
        rst = 1'b0;

        vecs[0]  = '{64'd1095216660225, 32'd255, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[1]  = '{64'd120, 32'd12, 32'd10, 32'd0, 1'b0};
        vecs[2]  = '{64'd108217, 32'd324, 32'd334, 32'd1, 1'b0};
        vecs[3]  = '{64'd1000, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
        vecs[4]  = '{64'd21474836480, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b1};
        vecs[5]  = '{64'd108216, 32'd324, 32'd334, 32'd0, 1'b0};
        vecs[6]  = '{64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{64'd7, 32'd1, 32'd7, 32'd0, 1'b0};
        vecs[8]  = '{64'h00000000_FFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[9]  = '{64'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0};
        vecs[10] = '{64'd12884901893, 32'd4, 32'd3221225473, 32'd1, 1'b0};

        for (int v = 0; v < 11; v++) begin
            ctx = $sformatf("vec%0d", v);
            run_op(vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].err, 1'b0);
        end

        // abort at the 10th run edge, then restart the same operands
        ctx        = "abort";
        bus.A      = 64'd108216;
        bus.B      = 32'd324;
        bus.enable = 1'b1;
        repeat (11) tick();
        check("running", 64'(state_dbg), 64'd1);
        rst = 1'b1;
        #1;
        check("Q_R_cleared", 64'({bus.Q, bus.R}), 64'd0);
        check("done_cleared", 64'(bus.done), 64'd0);
        tick();
        check("no_capture_in_reset", 64'(state_dbg), 64'd0);
        rst = 1'b0;
        ctx = "restart";
        run_op(64'd108216, 32'd324, 32'd334, 32'd0, 1'b0, 1'b0);

        // operands scrambled and enable dropped during the run
        ctx = "scramble0";
        run_op(64'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 1'b1);
        ctx = "scramble1";
        run_op(64'hFFFFFFFE_FFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1);

        // sweep with a reset pulse before every run
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 12; k++) begin
                ctx = $sformatf("sweep_%0d_%0d", i, k);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                run_op(64'(i * 12 + k), 32'd12, 32'(i), 32'(k), 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
